hs_arbiter: RTL and testbench

- N-channel four-phase req/ack arbiter that merges N bundled-data requesters into one four-phase output channel.
- Successor to the single-channel 16-bit req/ack CDC link. Generalised in data width, channel count and synchroniser depth.
- Adds round-robin arbitration and a data capture register.
- Sits at a domain boundary. Requests and the output acknowledge may come from foreign domains; everything inside runs on one local clock.

---
 rtl/hs_pkg.sv | 38 +++
 rtl/sync_ff.sv | 35 +++
 rtl/hs_arbiter.sv | 129 ++++++++++++
 tb/tb_hs_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared types and helpers for the hs_arbiter slice.
//   hs_state_e : arbiter FSM states.
//   rr_pick    : round-robin pick of the first set request at or after a pointer,
//                wrapping modulo the live channel count.
package hs_pkg;

  localparam int unsigned MaxChannels = 16;
  localparam int unsigned PickW       = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StWaitNack,
    StWaitRls
  } hs_state_e;

  // req is zero-extended to MaxChannels; only the low `channels` bits take part.
  function automatic logic [PickW-1:0] rr_pick(input logic [MaxChannels-1:0] req,
                                               input logic [PickW-1:0]       ptr,
                                               input int unsigned            channels);
    logic [PickW-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxChannels; i++) begin
      idx = 32'(ptr) + i;
      // ptr < channels and i < channels, so one subtraction is a full modulo
      if (idx >= channels) idx = idx - channels;
      if (!found && (i < channels) && req[idx[PickW-1:0]]) begin
        pick  = idx[PickW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser with asynchronous active-low clear.
//   clk   : local clock
//   rst_n : async active-low clear of every stage
//   d_i   : foreign-domain input
//   q_o   : d_i delayed by Depth flops (Depth = 0 is a wire)
module sync_ff #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o = d_i;
  end else begin : g_sync
    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(Depth); i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(Depth); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/hs_arbiter.sv
// N-channel four-phase req/ack arbiter merging bundled-data requesters into one
// four-phase output channel, with round-robin arbitration and a data capture register.
//   clk, rst_n : local clock, async active-low reset
//   req_i/ack_i: per-channel four-phase handshake (ack_i is driven here)
//   data_i     : per-channel data, channel k at [k*WIDTH +: WIDTH]
//   req_o/ack_o: output four-phase handshake (ack_o comes from the consumer)
//   data_o     : data captured at grant, held for the whole transaction
//   grant_o    : channel being served; busy_o: FSM not idle
module hs_arbiter
  import hs_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         req_i,
  input  logic [CHANNELS*WIDTH-1:0]   data_i,
  output logic [CHANNELS-1:0]         ack_i,
  output logic                        req_o,
  output logic [WIDTH-1:0]            data_o,
  input  logic                        ack_o,
  output logic [$clog2(CHANNELS)-1:0] grant_o,
  output logic                        busy_o
);

  localparam int unsigned GRANT_W = $clog2(CHANNELS);

  logic [CHANNELS-1:0] req_s;
  logic                ack_s;

  sync_ff #(.Width(CHANNELS), .Depth(SYNC_STAGES)) u_req_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (req_i),
    .q_o  (req_s)
  );

  sync_ff #(.Width(1), .Depth(SYNC_STAGES)) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (ack_o),
    .q_o  (ack_s)
  );

  logic [WIDTH-1:0] data_ch [CHANNELS];
  for (genvar k = 0; k < CHANNELS; k++) begin : g_data_ch
    assign data_ch[k] = data_i[k*WIDTH +: WIDTH];
  end

  hs_state_e           state_q, state_d;
  logic [GRANT_W-1:0]  ptr_q,   ptr_d;
  logic [GRANT_W-1:0]  grant_q, grant_d;
  logic [WIDTH-1:0]    data_q,  data_d;
  logic                req_q,   req_d;
  logic [CHANNELS-1:0] ack_q,   ack_d;

  logic [CHANNELS-1:0] eligible;
  logic [GRANT_W-1:0]  grant_pick;

  assign eligible   = req_s & ~ack_q;
  assign grant_pick = GRANT_W'(rr_pick(MaxChannels'(eligible), PickW'(ptr_q), CHANNELS));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    req_d   = req_q;
    ack_d   = ack_q;
    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          grant_d = grant_pick;
          data_d  = data_ch[grant_pick];
          req_d   = 1'b1;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = StWaitNack;
        end
      end
      StWaitNack: begin
        if (!ack_s) begin
          ack_d          = '0;
          ack_d[grant_q] = 1'b1;
          state_d        = StWaitRls;
        end
      end
      StWaitRls: begin
        if (!req_s[grant_q]) begin
          ack_d   = '0;
          ptr_d   = (grant_q == GRANT_W'(CHANNELS - 1)) ? '0 : grant_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
    end
  end

  assign ack_i   = ack_q;
  assign req_o   = req_q;
  assign data_o  = data_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_hs_arbiter.sv
// Self-checking bench for hs_arbiter: one DUT with two-stage synchronisers and one
// built with SYNC_STAGES=0. Expected grants are queued when requests are raised
// and popped when req_o rises.
module tb_hs_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT with SYNC_STAGES=2
  logic [N-1:0]   req_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   ack_i;
  logic           req_o;
  logic [W-1:0]   data_o;
  logic           ack_o;
  logic [GW-1:0]  grant_o;
  logic           busy_o;

  // DUT with SYNC_STAGES=0
  logic [N-1:0]   req_b;
  logic [N*W-1:0] data_b;
  logic [N-1:0]   ack_b;
  logic           req_ob;
  logic [W-1:0]   data_ob;
  logic           ack_ob;
  logic [GW-1:0]  grant_ob;
  logic           busy_ob;

  hs_arbiter #(.WIDTH(W), .CHANNELS(N), .SYNC_STAGES(2)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_i),
    .data_i (data_i),
    .ack_i  (ack_i),
    .req_o  (req_o),
    .data_o (data_o),
    .ack_o  (ack_o),
    .grant_o(grant_o),
    .busy_o (busy_o)
  );

  hs_arbiter #(.WIDTH(W), .CHANNELS(N), .SYNC_STAGES(0)) u_dut_s0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_b),
    .data_i (data_b),
    .ack_i  (ack_b),
    .req_o  (req_ob),
    .data_o (data_ob),
    .ack_o  (ack_ob),
    .grant_o(grant_ob),
    .busy_o (busy_ob)
  );

  typedef struct packed {
    logic [GW-1:0] grant;
    logic [W-1:0]  data;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic push_exp(input logic [GW-1:0] g);
    exp_t e;
    e.grant = g;
    e.data  = 16'(16'h1111 * (int'(g) + 1));
    sb_q.push_back(e);
  endtask

  task automatic wait_req_hi(output bit ok);
    int n;
    n = 0;
    while (req_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    ok = (req_o === 1'b1);
  endtask

  // Consumer acks after 3 cycles; requester releases once acknowledged.
  task automatic finish_txn(input logic [GW-1:0] g, input bit rereq, output bit ok);
    int n;
    ok = 1'b1;
    repeat (3) step();
    ack_o = 1'b1;
    n = 0;
    while (req_o !== 1'b0 && n < 40) begin step(); n++; end
    ok = ok & (req_o === 1'b0);
    ack_o = 1'b0;
    n = 0;
    while (ack_i[g] !== 1'b1 && n < 40) begin step(); n++; end
    ok = ok & (ack_i[g] === 1'b1);
    req_i[g] = 1'b0;
    n = 0;
    while (ack_i[g] !== 1'b0 && n < 40) begin step(); n++; end
    ok = ok & (ack_i[g] === 1'b0);
    if (rereq) req_i[g] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({ack_i, req_o, data_o, grant_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_a: ack=%b req=%b data=%h grant=%0d busy=%b expected all 0",
               ack_i, req_o, data_o, grant_o, busy_o);
    end
    checks++;
    if ({ack_b, req_ob, data_ob, grant_ob, busy_ob} !== '0) begin
      errors++;
      $display("FAIL reset_b: ack=%b req=%b data=%h grant=%0d busy=%b expected all 0",
               ack_b, req_ob, data_ob, grant_ob, busy_ob);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    exp_t e;
    int   n;
    data_i[0 +: W] = 16'h4444;
    e.grant = '0;
    e.data  = 16'h4444;
    sb_q.push_back(e);
    req_i[0] = 1'b1;
    step(); step();
    checks++;
    if (req_o !== 1'b0) begin
      errors++; $display("FAIL single_early: req_o=%b expected 0 after 2 cycles", req_o);
    end
    step();
    checks++;
    if (req_o !== 1'b1) begin
      errors++; $display("FAIL single_latency: req_o=%b expected 1 after 3 cycles", req_o);
    end
    e = sb_q.pop_front();
    checks++;
    if (grant_o !== e.grant) begin
      errors++; $display("FAIL single_grant: got %0d expected %0d", grant_o, e.grant);
    end
    checks++;
    if (data_o !== e.data) begin
      errors++; $display("FAIL single_data: got %h expected %h", data_o, e.data);
    end
    repeat (3) step();
    ack_o = 1'b1;
    n = 0;
    while (req_o !== 1'b0 && n < 40) begin step(); n++; end
    checks++;
    if (req_o !== 1'b0) begin
      errors++; $display("FAIL single_req_fall: req_o=%b expected 0 (timeout)", req_o);
    end
    ack_o = 1'b0;
    step(); step();
    checks++;
    if (ack_i !== 4'b0000) begin
      errors++; $display("FAIL single_ack_early: ack_i=%b expected 0000", ack_i);
    end
    step();
    checks++;
    if (ack_i !== 4'b0001) begin
      errors++; $display("FAIL single_ack_rise: ack_i=%b expected 0001", ack_i);
    end
    checks++;
    if (data_o !== 16'h4444) begin
      errors++; $display("FAIL single_data_hold: got %h expected 4444", data_o);
    end
    req_i[0] = 1'b0;
    repeat (3) step();
    checks++;
    if (ack_i !== 4'b0000 || busy_o !== 1'b0) begin
      errors++; $display("FAIL single_release: ack_i=%b busy=%b expected 0000/0", ack_i, busy_o);
    end
    data_i[0 +: W] = 16'h1111;
  endtask

  // Contention from reset, then a 1001 pair that shows the pointer wrapped to 0.
  task automatic test_contention();
    logic [GW-1:0] order [5];
    exp_t          e;
    bit            ok;
    order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd3};
    apply_reset();
    for (int k = 0; k < 5; k++) push_exp(order[k]);
    req_i = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) req_i = 4'b1001;
      wait_req_hi(ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || grant_o !== e.grant || data_o !== e.data) begin
        errors++;
        $display("FAIL contention_%0d: grant=%0d data=%h expected grant=%0d data=%h",
                 k, grant_o, data_o, e.grant, e.data);
      end
      finish_txn(grant_o, 1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL contention_hs_%0d: handshake timeout", k); end
    end
  endtask

  task automatic test_fairness();
    exp_t e;
    bit   ok;
    for (int k = 0; k < 6; k++) push_exp((k % 2 == 0) ? 2'd0 : 2'd2);
    req_i = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      wait_req_hi(ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || grant_o !== e.grant || data_o !== e.data) begin
        errors++;
        $display("FAIL fairness_%0d: grant=%0d data=%h expected grant=%0d data=%h",
                 k, grant_o, data_o, e.grant, e.data);
      end
      finish_txn(grant_o, (k < 4), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL fairness_hs_%0d: handshake timeout", k); end
    end
  endtask

  // Pointer is 3 after the fairness run ends on channel 2.
  task automatic test_wrap();
    exp_t e;
    bit   ok;
    push_exp(2'd0);
    push_exp(2'd1);
    req_i = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      wait_req_hi(ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || grant_o !== e.grant || data_o !== e.data) begin
        errors++;
        $display("FAIL wrap_%0d: grant=%0d data=%h expected grant=%0d data=%h",
                 k, grant_o, data_o, e.grant, e.data);
      end
      finish_txn(grant_o, 1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_hs_%0d: handshake timeout", k); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    push_exp(2'd2);
    req_i = 4'b0100;
    wait_req_hi(ok);
    checks++;
    if (!ok || busy_o !== 1'b1 || data_o !== 16'h3333) begin
      errors++; $display("FAIL rmid_pre: req=%b busy=%b data=%h expected 1/1/3333",
                         req_o, busy_o, data_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req_o !== 1'b0 || ack_i !== 4'b0000 || busy_o !== 1'b0 || data_o !== '0) begin
      errors++; $display("FAIL rmid_async: req=%b ack=%b busy=%b data=%h expected all 0",
                         req_o, ack_i, busy_o, data_o);
    end
    #2 rst_n = 1'b1;
    wait_req_hi(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || grant_o !== e.grant || data_o !== e.data) begin
      errors++; $display("FAIL rmid_regrant: grant=%0d data=%h expected grant=%0d data=%h",
                         grant_o, data_o, e.grant, e.data);
    end
    finish_txn(grant_o, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_hs: handshake timeout"); end
  endtask

  task automatic test_sync0();
    exp_t e;
    data_b[0 +: W] = 16'h4444;
    e.grant = '0;
    e.data  = 16'h4444;
    sb_q.push_back(e);
    req_b[0] = 1'b1;
    step();
    e = sb_q.pop_front();
    checks++;
    if (req_ob !== 1'b1 || grant_ob !== e.grant || data_ob !== e.data) begin
      errors++; $display("FAIL s0_grant: req=%b grant=%0d data=%h expected 1/%0d/%h",
                         req_ob, grant_ob, data_ob, e.grant, e.data);
    end
    repeat (2) step();
    ack_ob = 1'b1;
    step();
    checks++;
    if (req_ob !== 1'b0) begin
      errors++; $display("FAIL s0_req_fall: req=%b expected 0", req_ob);
    end
    ack_ob = 1'b0;
    step();
    checks++;
    if (ack_b !== 4'b0001) begin
      errors++; $display("FAIL s0_ack: ack=%b expected 0001", ack_b);
    end
    req_b[0] = 1'b0;
    step();
    checks++;
    if (ack_b !== 4'b0000 || busy_ob !== 1'b0) begin
      errors++; $display("FAIL s0_release: ack=%b busy=%b expected 0000/0", ack_b, busy_ob);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    req_i  = '0;
    req_b  = '0;
    ack_o  = 1'b0;
    ack_ob = 1'b0;
    for (int k = 0; k < N; k++) begin
      data_i[k*W +: W] = 16'(16'h1111 * (k + 1));
      data_b[k*W +: W] = '0;
    end
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_wrap();
    test_reset_mid();
    test_sync0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
